// File: rtl/seq_pkg.sv
// Shared encodings for the datapath sequencer: instruction classes, FSM states,
// flag indices and instruction field positions.
package seq_pkg;

   localparam int INST_W = 16;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'b00,
      CLS_BR   = 2'b01,
      CLS_HALT = 2'b10,
      CLS_NOP  = 2'b11
   } cls_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_PAUSE  = 3'd3,
      ST_HALTED = 3'd4
   } state_e;

   // Flag vector layout is {V,C,N,Z}; the branch selector indexes it directly.
   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   localparam int CLS_HI    = 15;
   localparam int CLS_LO    = 14;
   localparam int FS_HI     = 13;
   localparam int FS_LO     = 9;
   localparam int DA_HI     = 8;
   localparam int DA_LO     = 6;
   localparam int SA_HI     = 5;
   localparam int SA_LO     = 3;
   localparam int SB_HI     = 2;
   localparam int SB_LO     = 0;
   localparam int BR_POL    = 13;
   localparam int BR_SEL_HI = 12;
   localparam int BR_SEL_LO = 11;
   localparam int BR_UNC    = 10;

   function automatic logic br_taken(input logic       unc,
                                     input logic       pol,
                                     input logic [1:0] sel,
                                     input logic [3:0] flg);
      return unc | (flg[sel] == pol);
   endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// Program store: single-port RAM, synchronous write, registered read.
// The read register doubles as the instruction register, so it is reset.
module seq_prog_ram #(
   parameter int PROG_DEPTH = 16,
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [PROG_DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clock) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)     r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/datapath_sequencer.sv
// Microprogram controller for the register-file/ALU datapath: fetches from a
// 16-word program store, decodes, and drives SA/SB/DA/FS/WR with flag branches.
module datapath_sequencer
   import seq_pkg::*;
#(
   parameter int PROG_DEPTH = 16,
   parameter int ADDR_W     = 4,
   parameter int CNT_W      = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              step_mode,
   input  logic              step,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [15:0]       load_data,
   input  logic [3:0]        status,
   output logic [2:0]        SA,
   output logic [2:0]        SB,
   output logic [2:0]        DA,
   output logic [4:0]        FS,
   output logic              WR,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        flags,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  inst_count
);

   state_e              r_state, w_next;
   logic [ADDR_W-1:0]   r_pc;
   logic [3:0]          r_flags;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_step_d;
   logic [INST_W-1:0]   w_ir;
   logic                w_ctl_idle, w_step_rise, w_br_taken;
   cls_e                w_cls;
   logic [ADDR_W-1:0]   w_pc_inc, w_pc_exec, w_ram_addr;

   assign w_ctl_idle  = (r_state == ST_IDLE) || (r_state == ST_HALTED);
   assign w_step_rise = step & ~r_step_d;
   assign w_cls       = cls_e'(w_ir[CLS_HI:CLS_LO]);
   assign w_br_taken  = br_taken(w_ir[BR_UNC], w_ir[BR_POL],
                                 w_ir[BR_SEL_HI:BR_SEL_LO], r_flags);
   assign w_ram_addr  = w_ctl_idle ? load_addr : r_pc;

   seq_prog_ram #(
      .PROG_DEPTH (PROG_DEPTH),
      .ADDR_W     (ADDR_W),
      .DATA_W     (INST_W)
   ) u_prog (
      .clock   (clock),
      .reset   (reset),
      .i_we    (w_ctl_idle & load_en),
      .i_re    (r_state == ST_FETCH),
      .i_addr  (w_ram_addr),
      .i_wdata (load_data),
      .o_rdata (w_ir)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_HALTED: if (start) w_next = ST_FETCH;
         ST_FETCH:           w_next = ST_EXEC;
         ST_EXEC: begin
            if (w_cls == CLS_HALT) w_next = ST_HALTED;
            else if (step_mode)    w_next = ST_PAUSE;
            else                   w_next = ST_FETCH;
         end
         ST_PAUSE:           if (!step_mode || w_step_rise) w_next = ST_FETCH;
         default:            w_next = ST_IDLE;
      endcase
   end

   assign w_pc_inc = r_pc + ADDR_W'(1);

   always_comb begin
      w_pc_exec = w_pc_inc;
      case (w_cls)
         CLS_BR:   if (w_br_taken) w_pc_exec = w_ir[ADDR_W-1:0];
         CLS_HALT: w_pc_exec = r_pc;
         default:  ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_flags  <= '0;
         r_cnt    <= '0;
         r_step_d <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_step_d <= step;
         if (w_ctl_idle && start) begin
            r_pc <= '0;
         end else if (r_state == ST_EXEC) begin
            r_pc <= w_pc_exec;
            if (w_cls == CLS_ALU) r_flags <= status;
            if (r_cnt != '1)      r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Field outputs track ir in every state; only the write strobe is gated.
   assign FS         = w_ir[FS_HI:FS_LO];
   assign DA         = w_ir[DA_HI:DA_LO];
   assign SA         = w_ir[SA_HI:SA_LO];
   assign SB         = w_ir[SB_HI:SB_LO];
   assign WR         = (r_state == ST_EXEC) && (w_cls == CLS_ALU);
   assign pc         = r_pc;
   assign flags      = r_flags;
   assign busy       = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_PAUSE);
   assign halted     = (r_state == ST_HALTED);
   assign inst_count = r_cnt;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: expected write-strobe traces are
// queued as programs are loaded and compared against what the DUT emits.
module tb_datapath_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, step_mode = 1'b0, step = 1'b0, load_en = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [15:0] load_data = '0;
   logic [3:0]  status = '0;
   logic [2:0]  SA, SB, DA;
   logic [4:0]  FS;
   logic        WR, busy, halted;
   logic [3:0]  pc, flags;
   logic [7:0]  inst_count;

   int n_vec = 0;
   int n_err = 0;
   logic [13:0] exp_q[$];
   logic [13:0] obs_q[$];

   datapath_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .status(status),
      .SA(SA), .SB(SB), .DA(DA), .FS(FS), .WR(WR), .pc(pc), .flags(flags),
      .busy(busy), .halted(halted), .inst_count(inst_count)
   );

   always #5 clock = ~clock;

   // Record every register-file write the DUT issues.
   always @(negedge clock) if (!reset && WR) obs_q.push_back({FS, DA, SA, SB});

   function automatic logic [15:0] alu(input logic [4:0] fs, input logic [2:0] da,
                                       input logic [2:0] sa, input logic [2:0] sb);
      return {2'b00, fs, da, sa, sb};
   endfunction

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 0; load_en = 0; step = 0; step_mode = 0;
      tick(); tick();
      reset = 1'b0;
      tick();
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic load_word(input logic [3:0] a, input logic [15:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_halt(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         if (halted) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({WR, busy, halted} !== 3'b000) begin
         n_err++; $display("FAIL reset_ctl got WR/busy/halted=%b want 000", {WR, busy, halted});
      end
      n_vec++;
      if ({pc, flags, inst_count} !== 16'h0) begin
         n_err++; $display("FAIL reset_regs got pc=%0d flags=%b cnt=%0d want 0", pc, flags, inst_count);
      end
      n_vec++;
      if ({FS, DA, SA, SB} !== 14'h0) begin
         n_err++; $display("FAIL reset_fields got %h want 0", {FS, DA, SA, SB});
      end
   endtask

   task automatic test_alu_halt();
      bit ok;
      logic [13:0] e, o;
      do_reset();
      load_word(4'd0, 16'h0A11);
      load_word(4'd1, 16'h8000);
      exp_q.push_back(14'h0A11);
      pulse_start();
      wait_halt(40, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL alu_halt_timeout got halted=%b want 1", halted); end
      n_vec++;
      if (obs_q.size() !== exp_q.size()) begin
         n_err++; $display("FAIL alu_wr_cycles got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL alu_fields got %h want %h", o, e); end
      end
      n_vec++;
      if (pc !== 4'd1 || inst_count !== 8'd2) begin
         n_err++; $display("FAIL alu_halt_state got pc=%0d cnt=%0d want pc=1 cnt=2", pc, inst_count);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_branch();
      logic [3:0]  st_tab [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
      logic [15:0] br_tab [5] = '{16'h6003, 16'h6003, 16'h4803, 16'h4403, 16'h7803};
      logic [3:0]  pc_tab [5] = '{4'd3, 4'd2, 4'd2, 4'd3, 4'd3};
      bit ok;
      logic [7:0]  c0;
      logic [13:0] e, o;
      for (int k = 0; k < 5; k++) begin
         load_word(4'd0, 16'h0A11);
         load_word(4'd1, br_tab[k]);
         load_word(4'd2, 16'h8000);
         load_word(4'd3, 16'h8000);
         exp_q.push_back(14'h0A11);
         status = st_tab[k];
         c0 = inst_count;
         pulse_start();
         wait_halt(40, ok);
         n_vec++;
         if (!ok || pc !== pc_tab[k]) begin
            n_err++; $display("FAIL branch_pc case %0d got pc=%0d halted=%b want pc=%0d", k, pc, halted, pc_tab[k]);
         end
         n_vec++;
         if (flags !== st_tab[k]) begin
            n_err++; $display("FAIL branch_flags case %0d got %b want %b", k, flags, st_tab[k]);
         end
         n_vec++;
         if (inst_count !== c0 + 8'd3) begin
            n_err++; $display("FAIL branch_count case %0d got %0d want %0d", k, inst_count, c0 + 8'd3);
         end
         n_vec++;
         if (obs_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL branch_wr case %0d got %0d want %0d", k, obs_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL branch_fields got %h want %h", o, e); end
         end
         exp_q.delete(); obs_q.delete();
      end
      status = '0;
   endtask

   task automatic test_single_step();
      bit ok;
      logic [13:0] e, o;
      logic [15:0] wa, wb;
      do_reset();
      wa = alu(5'd1, 3'd1, 3'd1, 3'd1);
      wb = alu(5'd2, 3'd2, 3'd2, 3'd2);
      load_word(4'd0, wa);
      load_word(4'd1, wb);
      load_word(4'd2, 16'h8000);
      exp_q.push_back(wa[13:0]);
      exp_q.push_back(wb[13:0]);
      step_mode = 1'b1;
      pulse_start();
      tick(); tick();
      n_vec++;
      if ({busy, halted, WR} !== 3'b100 || pc !== 4'd1) begin
         n_err++; $display("FAIL step_pause1 got busy/halted/WR=%b pc=%0d want 100 pc=1", {busy, halted, WR}, pc);
      end
      repeat (5) tick();
      n_vec++;
      if (pc !== 4'd1 || obs_q.size() !== 1) begin
         n_err++; $display("FAIL step_hold got pc=%0d writes=%0d want pc=1 writes=1", pc, obs_q.size());
      end
      step = 1'b1;
      repeat (10) tick();
      n_vec++;
      if (pc !== 4'd2 || busy !== 1'b1 || obs_q.size() !== 2) begin
         n_err++; $display("FAIL step_once got pc=%0d busy=%b writes=%0d want pc=2 busy=1 writes=2", pc, busy, obs_q.size());
      end
      step = 1'b0;
      step_mode = 1'b0;
      wait_halt(10, ok);
      n_vec++;
      if (!ok || pc !== 4'd2 || inst_count !== 8'd3) begin
         n_err++; $display("FAIL step_release got halted=%b pc=%0d cnt=%0d want 1 2 3", halted, pc, inst_count);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL step_fields got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_wrap_sat();
      int wraps = 0, bad = 0;
      logic [3:0] prev;
      do_reset();
      for (int a = 0; a < 16; a++) load_word(4'(a), 16'hC000);
      pulse_start();
      prev = pc;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (prev == 4'd15 && pc == 4'd0) wraps++;
         if (pc != prev && pc != prev + 4'd1) bad++;
         prev = pc;
      end
      n_vec++;
      if (wraps !== 6 || bad !== 0) begin
         n_err++; $display("FAIL wrap got wraps=%0d bad=%0d want 6 0", wraps, bad);
      end
      n_vec++;
      if (inst_count !== 8'd100) begin
         n_err++; $display("FAIL count_rate got %0d want 100", inst_count);
      end
      repeat (500) tick();
      n_vec++;
      if (inst_count !== 8'd255) begin
         n_err++; $display("FAIL count_sat got %0d want 255", inst_count);
      end
      n_vec++;
      if (obs_q.size() !== 0 || busy !== 1'b1) begin
         n_err++; $display("FAIL nop_loop got writes=%0d busy=%b want 0 1", obs_q.size(), busy);
      end
   endtask

   task automatic test_load_busy();
      bit ok;
      logic [13:0] e, o;
      logic [15:0] wa, wb;
      do_reset();
      wa = alu(5'd3, 3'd1, 3'd2, 3'd3);
      wb = alu(5'd7, 3'd4, 3'd5, 3'd6);
      load_word(4'd0, wa);
      load_word(4'd1, wb);
      load_word(4'd2, 16'h8000);
      for (int run = 0; run < 2; run++) begin
         exp_q.push_back(wa[13:0]);
         exp_q.push_back(wb[13:0]);
         pulse_start();
         if (run == 0) begin
            load_en = 1'b1; load_addr = 4'd1; load_data = alu(5'd31, 3'd7, 3'd7, 3'd7);
            tick();
            load_addr = 4'd2; load_data = 16'hC000;
            tick(); tick();
            load_en = 1'b0;
         end
         wait_halt(40, ok);
         n_vec++;
         if (!ok || pc !== 4'd2 || obs_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL load_busy run %0d got halted=%b pc=%0d writes=%0d want 1 2 %0d", run, halted, pc, obs_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_err++; $display("FAIL load_busy_fields run %0d got %h want %h", run, o, e); end
         end
         exp_q.delete(); obs_q.delete();
      end
   endtask

   task automatic test_reset_exec();
      bit ok;
      int seen = 0;
      logic [13:0] e, o;
      logic [15:0] wa, wb;
      wa = alu(5'd3, 3'd1, 3'd2, 3'd3);
      wb = alu(5'd7, 3'd4, 3'd5, 3'd6);
      status = 4'b1111;
      pulse_start();
      for (int i = 0; i < 20 && seen < 2; i++) begin
         @(negedge clock);
         if (WR) seen++;
      end
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if (seen !== 2 || WR !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
         n_err++; $display("FAIL reset_exec_ctl got seen=%0d WR=%b busy=%b halted=%b want 2 0 0 0", seen, WR, busy, halted);
      end
      n_vec++;
      if (pc !== 4'd0 || flags !== 4'd0 || inst_count !== 8'd0) begin
         n_err++; $display("FAIL reset_exec_regs got pc=%0d flags=%b cnt=%0d want 0", pc, flags, inst_count);
      end
      #1 reset = 1'b0;
      tick();
      exp_q.delete(); obs_q.delete();
      exp_q.push_back(wa[13:0]);
      exp_q.push_back(wb[13:0]);
      pulse_start();
      wait_halt(40, ok);
      n_vec++;
      if (!ok || obs_q.size() !== exp_q.size() || flags !== 4'b1111) begin
         n_err++; $display("FAIL reset_rerun got halted=%b writes=%0d flags=%b want 1 %0d 1111", halted, obs_q.size(), exp_q.size(), flags);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_vec++;
         if (o !== e) begin n_err++; $display("FAIL reset_rerun_fields got %h want %h", o, e); end
      end
      status = '0;
   endtask

   initial begin
      test_reset();
      test_alu_halt();
      test_branch();
      test_single_step();
      test_wrap_sat();
      test_load_busy();
      test_reset_exec();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
